// File: rtl/cell_row_reader_pkg.sv
// Shared definitions for the cell row reader: screen geometry, the 32-bit
// character cell layout, the blank cell and the cell address map.
package cell_row_reader_pkg;

  localparam int unsigned COLUMNS = 80;
  localparam int unsigned ROWS    = 51;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned COL_W   = 7;
  localparam int unsigned ROW_W   = 6;
  localparam int unsigned ADDR_W  = 23;

  // Fields listed MSB first so the packed layout matches the cell word.
  typedef struct packed {
    logic [3:0] background;  // [31:28]
    logic [3:0] foreground;  // [27:24]
    logic [3:0] pattern;     // [23:20]
    logic [1:0] func;        // [19:18]
    logic       underline;   // 17
    logic       invert;      // 16
    logic [1:0] blink;       // [15:14]
    logic [1:0] part;        // [13:12]
    logic [1:0] size;        // [11:10]
    logic [9:0] ord;         // [9:0]
  } cell_t;

  // Space character, foreground 15, background 0, function OR (= 32'h0F04_0020).
  localparam cell_t BLANK_CELL = '{
    background: 4'h0,
    foreground: 4'hF,
    pattern:    4'h0,
    func:       2'b01,
    underline:  1'b0,
    invert:     1'b0,
    blink:      2'b00,
    part:       2'b00,
    size:       2'b00,
    ord:        10'h020
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Byte address of cell (x, y): 4 * (y * COLUMNS + x), zero-extended to 23 bits.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] y,
                                                  input logic [COL_W-1:0] x);
    logic [ADDR_W-1:0] lin;
    lin = ADDR_W'(y) * ADDR_W'(COLUMNS) + ADDR_W'(x);
    return lin << 2;
  endfunction

endpackage

// File: rtl/cell_row_reader_buffer.sv
// cell_line_buffer: one bank of COLUMNS cells, simple dual-port RAM with a
// single write port and a registered read port (read-before-write).
module cell_line_buffer
  import cell_row_reader_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [COL_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [COL_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [COLUMNS];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [COL_W-1:0]  rd_sel;

  // Out-of-range read indices are folded to 0; the top replaces them with the blank cell.
  always_comb begin
    rd_sel    = (rd_idx < COL_W'(COLUMNS)) ? rd_idx : '0;
    rd_data_d = mem[rd_sel];
  end

  // Write port and read register; contents are never cleared.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_idx < COL_W'(COLUMNS))) begin
      mem[wr_idx] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/cell_row_reader.sv
// cell_row_reader: fetches one text row of cells from SDRAM into a line
// buffer and serves the video pipeline through a registered read port.
// Optional feature macro: CELL_ROW_READER_DOUBLE_BUFFER_EN (two banks with
// fill/display swap); without it a single bank is both filled and displayed.
module cell_row_reader
  import cell_row_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ROW_W-1:0]  fetch_row,
  input  logic              fetch_start,
  output logic              busy,
  output logic              fetch_done,
  input  logic              line_swap,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_request,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_done,
  input  logic [COL_W-1:0]  cell_x,
  output logic [DATA_W-1:0] cell_data
);

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              busy_q, busy_d;
  logic              fetch_done_q, fetch_done_d;
  logic              rd_request_q, rd_request_d;
  logic [ADDR_W-1:0] rd_address_q, rd_address_d;
  logic              wr_en;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_blank_q, rd_blank_d;
  logic [DATA_W-1:0] bank_rd_data;

  // Fetch sequencer: the request strobe and address are registered on entry
  // to REQUEST so rd_request is high exactly while the FSM sits in REQUEST.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    busy_d       = busy_q;
    fetch_done_d = 1'b0;
    rd_request_d = 1'b0;
    rd_address_d = rd_address_q;
    wr_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_start && (fetch_row < ROW_W'(ROWS))) begin
          row_d        = fetch_row;
          col_d        = '0;
          busy_d       = 1'b1;
          rd_request_d = 1'b1;
          rd_address_d = cell_addr(fetch_row, '0);
          state_d      = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rd_done) begin
          // A completion arriving in the reset cycle must not touch the buffer.
          wr_en = !reset;
          if (col_q == COL_W'(COLUMNS - 1)) begin
            state_d = ST_DONE;
          end else begin
            col_d        = col_q + COL_W'(1);
            rd_request_d = 1'b1;
            rd_address_d = cell_addr(row_q, col_q + COL_W'(1));
            state_d      = ST_REQUEST;
          end
        end
      end
      ST_DONE: begin
        fetch_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      busy_q       <= 1'b0;
      fetch_done_q <= 1'b0;
      rd_request_q <= 1'b0;
      rd_address_q <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      busy_q       <= busy_d;
      fetch_done_q <= fetch_done_d;
      rd_request_q <= rd_request_d;
      rd_address_q <= rd_address_d;
    end
  end

`ifdef CELL_ROW_READER_DOUBLE_BUFFER_EN
  logic              disp_q, disp_d;
  logic              pend_q, pend_d;
  logic              rd_bank_q, rd_bank_d;
  logic [DATA_W-1:0] bank0_rd_data, bank1_rd_data;

  // Bank swap: immediate when idle, otherwise held (one deep) and applied on
  // the edge that raises fetch_done so the display never sees a partial row.
  always_comb begin
    disp_d    = disp_q;
    pend_d    = pend_q;
    rd_bank_d = disp_q;
    if (state_q == ST_DONE) begin
      if (pend_q || line_swap) begin
        disp_d = ~disp_q;
      end
      pend_d = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (line_swap) begin
        pend_d = 1'b1;
      end
    end else if (line_swap) begin
      disp_d = ~disp_q;
    end
  end

  // Swap control registers; rd_bank_q follows the RAM read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q    <= 1'b0;
      pend_q    <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  cell_line_buffer u_bank0 (
    .clk     (clk),
    .wr_en   (wr_en && disp_q),
    .wr_idx  (col_q),
    .wr_data (rd_data),
    .rd_idx  (cell_x),
    .rd_data (bank0_rd_data)
  );

  cell_line_buffer u_bank1 (
    .clk     (clk),
    .wr_en   (wr_en && !disp_q),
    .wr_idx  (col_q),
    .wr_data (rd_data),
    .rd_idx  (cell_x),
    .rd_data (bank1_rd_data)
  );

  assign bank_rd_data = rd_bank_q ? bank1_rd_data : bank0_rd_data;
`else
  logic unused_line_swap;

  assign unused_line_swap = line_swap;

  cell_line_buffer u_bank0 (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (col_q),
    .wr_data (rd_data),
    .rd_idx  (cell_x),
    .rd_data (bank_rd_data)
  );
`endif

  // Read-port qualifiers registered alongside the RAM read.
  always_comb begin
    rd_vld_d   = 1'b1;
    rd_blank_d = (cell_x >= COL_W'(COLUMNS));
  end

  // Read-port control flags; rd_vld_q holds cell_data at zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q   <= 1'b0;
      rd_blank_q <= 1'b0;
    end else begin
      rd_vld_q   <= rd_vld_d;
      rd_blank_q <= rd_blank_d;
    end
  end

  // Output select: zero after reset, blank cell past the row end, else RAM data.
  always_comb begin
    cell_data = '0;
    if (rd_vld_q) begin
      cell_data = rd_blank_q ? BLANK_CELL : bank_rd_data;
    end
  end

  assign busy       = busy_q;
  assign fetch_done = fetch_done_q;
  assign rd_request = rd_request_q;
  assign rd_address = rd_address_q;

endmodule
